// File: rtl/hall98_pkg.sv
// Shared definitions for the hall98 issue unit: instruction word layout,
// opcode values, controller states and the opcode legality check.
package hall98_pkg;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h45;
  localparam logic [7:0] OP_ADD  = 8'h46;
  localparam logic [7:0] OP_SUB  = 8'h47;
  localparam logic [7:0] OP_MUL  = 8'h48;
  localparam logic [7:0] OP_LDR  = 8'h49;
  localparam logic [7:0] OP_STR  = 8'h4A;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 24;
  localparam int FLAG_BIT = 23;
  localparam int RE_HI    = 22;
  localparam int RE_LO    = 20;
  localparam int N_HI     = 19;
  localparam int N_LO     = 0;

  // Destination registers r1..r4 exist on the core; r0 and r5..r7 do not.
  localparam logic [2:0] RE_MIN = 3'd1;
  localparam logic [2:0] RE_MAX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_MUL) || (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/hall98_prog_mem.sv
// Single-port program RAM: synchronous write, registered one-cycle read.
module hall98_prog_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // No reset: program contents and read data survive ireset_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hall98_issuer.sv
// Instruction issue unit: fetches program words, checks them and presents
// opcode/re/n/flag to the hall98 core through a valid/ready handshake.
module hall98_issuer
  import hall98_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          iclock,
  input  logic          ireset_n,
  input  logic          start,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   opcode,
  output logic [31:0]   re,
  output logic [31:0]   n,
  output logic          flag,
  output logic [AW-1:0] pc,
  output logic [15:0]   issued_cnt,
  output logic          busy,
  output logic          done,
  output logic          fault
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state, state_nxt;
  logic [AW-1:0] pc_q;
  logic [15:0]   cnt_q;

  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   word_p1;

  logic [7:0]    dec_opc;
  logic [2:0]    dec_re;
  logic          dec_ok;
  logic          accept;
  logic          last_word;

  logic [7:0]    opc_p2;
  logic [2:0]    re_p2;
  logic [19:0]   n_p2;
  logic          flag_p2;

  // Stage p0 -> p1: the RAM port is shared between loading (IDLE) and fetch.
  assign mem_we   = (state == ST_IDLE) && wr_en;
  assign mem_re   = (state == ST_FETCH);
  assign mem_addr = (state == ST_IDLE) ? wr_addr : pc_q;

  hall98_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (iclock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (word_p1)
  );

  // Stage p1 -> p2: decode and legality check of the fetched word.
  assign dec_opc   = word_p1[OPC_HI:OPC_LO];
  assign dec_re    = word_p1[RE_HI:RE_LO];
  assign dec_ok    = is_legal_op(dec_opc) && (dec_re >= RE_MIN) && (dec_re <= RE_MAX);
  assign accept    = (state == ST_ISSUE) && out_ready;
  assign last_word = (pc_q == AW'(DEPTH - 1));

  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec_opc == OP_HALT) begin
          state_nxt = ST_DONE;
        end else if (!dec_ok) begin
          state_nxt = ST_FAULT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:  if (out_ready) state_nxt = last_word ? ST_DONE : ST_FETCH;
      ST_DONE,
      ST_FAULT:  if (clr) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // pc stops on the last word rather than wrapping, and on a faulting word.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        pc_q  <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= sat_inc16(cnt_q);
        if (!last_word) begin
          pc_q <= pc_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge iclock) begin
    if (state == ST_DECODE) begin
      opc_p2  <= dec_opc;
      re_p2   <= dec_re;
      n_p2    <= word_p1[N_HI:N_LO];
      flag_p2 <= word_p1[FLAG_BIT];
    end
  end

  // Issue: fields are forced to zero whenever nothing is being offered.
  assign out_valid  = (state == ST_ISSUE);
  assign opcode     = out_valid ? {24'd0, opc_p2} : 32'd0;
  assign re         = out_valid ? {29'd0, re_p2}  : 32'd0;
  assign n          = out_valid ? {12'd0, n_p2}   : 32'd0;
  assign flag       = out_valid & flag_p2;
  assign pc         = pc_q;
  assign issued_cnt = cnt_q;
  assign busy       = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_ISSUE);
  assign done       = (state == ST_DONE);
  assign fault      = (state == ST_FAULT);

endmodule
